// File: rtl/data_sram_pkg.sv
// Shared constants, read-mux select type and byte-merge helper for the data-side SRAM responder.
package data_sram_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NBYTES = DATA_W / 8;

    localparam logic [15:0] MMIO_BASE_DEF = 16'hBFAF;

    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_TIMER   = 16'hE000;
    localparam logic [15:0] OFF_COMPARE = 16'hE004;
    localparam logic [15:0] OFF_STATUS  = 16'hE008;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_MMIO = 2'd2
    } rsel_e;

    // Replace each byte lane of old_w whose enable bit is set with the matching lane of new_w.
    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NBYTES-1:0] wen);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (wen[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// Byte-enable, write-first, synchronous-read word RAM (contents are never reset).
module sram_bank
    import data_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic [NBYTES-1:0] wen,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read port returns the merged word so a write cycle sees its own data.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= byte_merge(mem[idx], wdata, wen);
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// CPU data-port responder: decodes requests to the word RAM or the LED/timer/compare/status MMIO block.
module data_sram_resp
    import data_sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter int unsigned LED_W     = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sram_en,
    input  logic [NBYTES-1:0] sram_wen,
    input  logic [31:0]       sram_addr,
    input  logic [DATA_W-1:0] sram_wdata,
    output logic [DATA_W-1:0] sram_rdata,
    output logic [LED_W-1:0]  led,
    output logic              timer_irq
);

    logic              mmio_sel;
    logic              ram_en;
    logic              mmio_wr;
    logic              irq_clr;
    logic              match;
    logic [15:0]       off;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] led_merged;
    logic [DATA_W-1:0] timer_merged;
    logic [DATA_W-1:0] cmp_merged;
    logic [DATA_W-1:0] mmio_rdata_c;
    logic [DATA_W-1:0] mmio_rdata_q;
    logic [DATA_W-1:0] timer_q;
    logic [DATA_W-1:0] compare_q;
    logic [LED_W-1:0]  led_q;
    logic              irq_q;
    rsel_e             sel_q;
    logic              unused;

    assign mmio_sel = (sram_addr[31:16] == MMIO_BASE);
    assign off      = {sram_addr[15:2], 2'b00};
    // Gating with resetn keeps an access caught by reset from committing to the RAM.
    assign ram_en   = sram_en && !mmio_sel && resetn;
    assign mmio_wr  = sram_en && mmio_sel && (sram_wen != '0);

    assign led_merged   = byte_merge(DATA_W'(led_q), sram_wdata, sram_wen);
    assign timer_merged = byte_merge(timer_q, sram_wdata, sram_wen);
    assign cmp_merged   = byte_merge(compare_q, sram_wdata, sram_wen);
    assign irq_clr      = mmio_wr && (off == OFF_STATUS) && sram_wen[0] && sram_wdata[0];
    assign match        = (timer_q == compare_q);
    assign unused       = ^{sram_addr[1:0], led_merged};

    sram_bank #(
        .ADDR_W(ADDR_W)
    ) u_bank (
        .clk  (clk),
        .en   (ram_en),
        .wen  (sram_wen),
        .idx  (sram_addr[ADDR_W+1:2]),
        .wdata(sram_wdata),
        .rdata(ram_rdata)
    );

    // MMIO read value: post-write register contents; TIMER shows its pre-increment value.
    always_comb begin
        mmio_rdata_c = '0;
        case (off)
            OFF_LED:     mmio_rdata_c = DATA_W'(led_merged[LED_W-1:0]);
            OFF_TIMER:   mmio_rdata_c = timer_merged;
            OFF_COMPARE: mmio_rdata_c = cmp_merged;
            OFF_STATUS:  mmio_rdata_c = {{(DATA_W-1){1'b0}}, irq_q & ~irq_clr};
            default:     mmio_rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q        <= '0;
            timer_q      <= '0;
            compare_q    <= '1;
            irq_q        <= 1'b0;
            mmio_rdata_q <= '0;
            sel_q        <= SEL_NONE;
        end else begin
            timer_q <= (mmio_wr && (off == OFF_TIMER)) ? timer_merged : timer_q + 32'd1;
            irq_q   <= match | (irq_q & ~irq_clr);
            if (mmio_wr && (off == OFF_LED))     led_q     <= led_merged[LED_W-1:0];
            if (mmio_wr && (off == OFF_COMPARE)) compare_q <= cmp_merged;
            if (sram_en) begin
                sel_q <= mmio_sel ? SEL_MMIO : SEL_RAM;
                if (mmio_sel) mmio_rdata_q <= mmio_rdata_c;
            end
        end
    end

    // Registered select lines up with the RAM's one-cycle read latency.
    always_comb begin
        sram_rdata = '0;
        case (sel_q)
            SEL_RAM:  sram_rdata = ram_rdata;
            SEL_MMIO: sram_rdata = mmio_rdata_q;
            default:  sram_rdata = '0;
        endcase
    end

    assign led       = led_q;
    assign timer_irq = irq_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: transaction-level model checked every cycle plus hand-computed literals.
module tb_data_sram_resp;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned LED_W  = 16;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic        en     = 1'b0;
    logic [3:0]  wen    = 4'h0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic [31:0] sram_rdata;
    logic [LED_W-1:0] led;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_sram_resp #(
        .ADDR_W   (ADDR_W),
        .MMIO_BASE(16'hBFAF),
        .LED_W    (LED_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sram_en   (en),
        .sram_wen  (wen),
        .sram_addr (addr),
        .sram_wdata(wdata),
        .sram_rdata(sram_rdata),
        .led       (led),
        .timer_irq (timer_irq)
    );

    // Model state: what the bus-visible registers and memory must hold.
    logic [31:0] m_ram [int];
    logic [15:0] m_led      = 16'h0;
    logic [31:0] m_timer    = 32'h0;
    logic [31:0] m_cmp      = 32'hFFFF_FFFF;
    logic        m_irq      = 1'b0;
    logic [31:0] m_rdata    = 32'h0;
    bit          m_rd_known = 1'b1;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] nw;
        logic [31:0] tnext;
        logic [15:0] off;
        logic        clr;
        logic        hit;
        int          idx;
        hit   = (m_timer == m_cmp);
        clr   = 1'b0;
        tnext = m_timer + 32'd1;
        if (en) begin
            m_rd_known = 1'b1;
            if (addr[31:16] == 16'hBFAF) begin
                off = {addr[15:2], 2'b00};
                case (off)
                    16'hF000: begin
                        nw = merge({16'h0, m_led}, wdata, wen);
                        m_led = nw[15:0];
                        m_rdata = {16'h0, nw[15:0]};
                    end
                    16'hE000: begin
                        nw = merge(m_timer, wdata, wen);
                        m_rdata = nw;
                        if (wen != 4'h0) tnext = nw;
                    end
                    16'hE004: begin
                        nw = merge(m_cmp, wdata, wen);
                        m_cmp = nw;
                        m_rdata = nw;
                    end
                    16'hE008: begin
                        clr = wen[0] && wdata[0];
                        m_rdata = {31'h0, m_irq && !clr};
                    end
                    default: m_rdata = 32'h0;
                endcase
            end else begin
                idx = int'(addr[ADDR_W+1:2]);
                if (m_ram.exists(idx)) begin
                    nw = merge(m_ram[idx], wdata, wen);
                    m_rdata = nw;
                    m_ram[idx] = nw;
                end else if (wen == 4'hF) begin
                    m_rdata = wdata;
                    m_ram[idx] = wdata;
                end else begin
                    m_rd_known = 1'b0;
                end
            end
        end
        m_irq   = hit || (m_irq && !clr);
        m_timer = tnext;
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_led      = 16'h0;
            m_timer    = 32'h0;
            m_cmp      = 32'hFFFF_FFFF;
            m_irq      = 1'b0;
            m_rdata    = 32'h0;
            m_rd_known = 1'b1;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (m_rd_known) check("rdata", sram_rdata, m_rdata);
        check("led", 32'(led), 32'(m_led));
        check("irq", 32'(timer_irq), 32'(m_irq));
    end

    task automatic req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; addr = a; wen = w; wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0; wen = 4'h0;
        end
    endtask

    localparam logic [31:0] A_LED  = 32'hBFAF_F000;
    localparam logic [31:0] A_TMR  = 32'hBFAF_E000;
    localparam logic [31:0] A_CMP  = 32'hBFAF_E004;
    localparam logic [31:0] A_STAT = 32'hBFAF_E008;

    logic [31:0] t1, t2;

    initial begin
        #1 resetn = 1'b0;
        #2;
        check("rst_rdata", sram_rdata, 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        req(A_LED, 4'h0, 32'h0); idle(1);
        check("led_read0", sram_rdata, 32'h0);

        // Two TIMER reads 7 cycles apart.
        req(A_TMR, 4'h0, 32'h0); idle(1);
        t1 = sram_rdata;
        idle(5);
        req(A_TMR, 4'h0, 32'h0); idle(1);
        t2 = sram_rdata;
        check("timer_delta", t2 - t1, 32'd7);

        req(32'h0000_0010, 4'hF, 32'hDEAD_BEEF); idle(1);
        check("ram_full_wr", sram_rdata, 32'hDEAD_BEEF);
        req(32'h0000_0010, 4'b0010, 32'h0000_5500); idle(1);
        check("ram_byte_wr_first", sram_rdata, 32'hDEAD_55EF);
        req(32'h0000_0010, 4'h0, 32'h0); idle(1);
        check("ram_byte_rd", sram_rdata, 32'hDEAD_55EF);
        req(32'h0000_0013, 4'h0, 32'h0); idle(1);
        check("ram_low_bits", sram_rdata, 32'hDEAD_55EF);

        req(32'h0000_000C, 4'hF, 32'h1234_5678); idle(1);
        req(32'h0000_000C + (32'h1 << (ADDR_W + 2)), 4'h0, 32'h0); idle(1);
        check("ram_alias", sram_rdata, 32'h1234_5678);

        // COMPARE=20, TIMER=10: match seen in the cycle timer reads 20, flag set at the following edge.
        req(A_CMP, 4'hF, 32'd20);
        req(A_TMR, 4'hF, 32'd10);
        idle(1);
        idle(10);
        check("irq_before", 32'(timer_irq), 32'h0);
        idle(1);
        check("irq_rise", 32'(timer_irq), 32'h1);
        idle(5);
        check("irq_sticky", 32'(timer_irq), 32'h1);
        req(A_STAT, 4'h0, 32'h0); idle(1);
        check("status_rd", sram_rdata, 32'h1);
        req(A_STAT, 4'b0001, 32'h1); idle(1);
        check("irq_w1c", 32'(timer_irq), 32'h0);

        // W1C lands on the same edge the match sets the flag.
        req(A_CMP, 4'hF, 32'd100);
        req(A_TMR, 4'hF, 32'd90);
        idle(10);
        req(A_STAT, 4'b0001, 32'h1); idle(1);
        check("irq_set_wins", 32'(timer_irq), 32'h1);
        idle(2);
        req(A_STAT, 4'b0001, 32'h1); idle(1);
        check("irq_w1c2", 32'(timer_irq), 32'h0);

        req(A_LED, 4'b0001, 32'hFFFF_ABCD); idle(1);
        check("led_byte", 32'(led), 32'h0000_00CD);
        check("led_wr_rd", sram_rdata, 32'h0000_00CD);
        req(32'hBFAF_0000, 4'hF, 32'h1234_5678); idle(1);
        check("unmapped", sram_rdata, 32'h0);
        check("unmapped_led", 32'(led), 32'h0000_00CD);
        req(A_CMP, 4'h0, 32'h0); idle(1);
        check("cmp_kept", sram_rdata, 32'd100);

        // Reset lands in the middle of a write burst.
        req(32'h0000_0020, 4'hF, 32'hA5A5_A5A5);
        req(32'h0000_0024, 4'hF, 32'h5A5A_5A5A);
        req(32'h0000_0024, 4'b1100, 32'hFFFF_0000);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_rdata", sram_rdata, 32'h0);
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_irq", 32'(timer_irq), 32'h0);
        en = 1'b0; wen = 4'h0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        req(A_CMP, 4'h0, 32'h0); idle(1);
        check("rst_cmp", sram_rdata, 32'hFFFF_FFFF);
        req(32'h0000_0020, 4'h0, 32'h0); idle(1);
        check("ram_keep_20", sram_rdata, 32'hA5A5_A5A5);
        req(32'h0000_0024, 4'h0, 32'h0); idle(1);
        check("ram_keep_24", sram_rdata, 32'h5A5A_5A5A);
        req(32'h0000_0010, 4'h0, 32'h0); idle(1);
        check("ram_keep_10", sram_rdata, 32'hDEAD_55EF);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
